// File: rtl/instr_fetch_decode_pkg.sv
// Shared widths, opcode map, instruction layout and fetch FSM states for the proc front end.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package instr_fetch_decode_pkg;

   localparam int OPCODE_WIDTH = 6;
   localparam int MEM_WIDTH    = 5;
   localparam int PC_WIDTH     = 8;
   localparam int INSTR_WIDTH  = OPCODE_WIDTH + 3 * (2 + MEM_WIDTH);

   typedef enum logic [OPCODE_WIDTH-1:0] {
      NOP_OP   = 6'd0,
      ADD_OP   = 6'd1,
      SUB_OP   = 6'd2,
      AND_OP   = 6'd3,
      OR_OP    = 6'd4,
      XOR_OP   = 6'd5,
      SHL_OP   = 6'd6,
      SHR_OP   = 6'd7,
      LOAD_OP  = 6'd8,
      STORE_OP = 6'd9,
      MOV_OP   = 6'd10,
      CMP_OP   = 6'd11,
      JMP_OP   = 6'd12,
      JZ_OP    = 6'd13,
      HALT_OP  = 6'd14
   } opcode_e;

   // Any opcode at or above this value is outside the defined map.
   localparam logic [OPCODE_WIDTH-1:0] NUM_OPS = 6'd15;

   // Operand selector encodings; the front end passes them through untouched.
   localparam logic [1:0] CHOICE_REG = 2'd0;
   localparam logic [1:0] CHOICE_MEM = 2'd1;
   localparam logic [1:0] CHOICE_IMM = 2'd2;
   localparam logic [1:0] CHOICE_IND = 2'd3;

   // Field order MSB to LSB matches the program memory word.
   typedef struct packed {
      logic [OPCODE_WIDTH-1:0] op_code;
      logic [1:0]              source1_choice;
      logic [MEM_WIDTH-1:0]    source1_addr;
      logic [1:0]              source2_choice;
      logic [MEM_WIDTH-1:0]    source2_addr;
      logic [1:0]              dest_choice;
      logic [MEM_WIDTH-1:0]    dest_addr;
   } instr_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      HOLD,
      HALTED
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bundles program-memory, jump and decoded-instruction signals between fetch and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready toward execute; prog_rd_en/prog_valid toward memory.
interface instr_fetch_decode_if;
   import instr_fetch_decode_pkg::*;

   logic [PC_WIDTH-1:0]     prog_addr;
   logic                    prog_rd_en;
   logic [INSTR_WIDTH-1:0]  prog_data;
   logic                    prog_valid;
   logic                    jump_en;
   logic [PC_WIDTH-1:0]     jump_addr;
   logic [OPCODE_WIDTH-1:0] op_code;
   logic [MEM_WIDTH-1:0]    source1_addr;
   logic [MEM_WIDTH-1:0]    source2_addr;
   logic [MEM_WIDTH-1:0]    dest_addr;
   logic [1:0]              source1_choice;
   logic [1:0]              source2_choice;
   logic [1:0]              dest_choice;
   logic                    instr_valid;
   logic                    instr_ready;
   logic [PC_WIDTH-1:0]     pc_out;
   logic                    halted;
   logic                    illegal_op;

   // Fetch/decode side.
   modport master (
      output prog_addr, prog_rd_en,
      input  prog_data, prog_valid,
      input  jump_en, jump_addr,
      output op_code, source1_addr, source2_addr, dest_addr,
      output source1_choice, source2_choice, dest_choice,
      output instr_valid,
      input  instr_ready,
      output pc_out, halted, illegal_op
   );

   // Memory and execute side.
   modport slave (
      input  prog_addr, prog_rd_en,
      output prog_data, prog_valid,
      output jump_en, jump_addr,
      input  op_code, source1_addr, source2_addr, dest_addr,
      input  source1_choice, source2_choice, dest_choice,
      input  instr_valid,
      output instr_ready,
      input  pc_out, halted, illegal_op
   );
endinterface

// File: rtl/instr_decoder.sv
// Splits a program word into its fields and flags opcodes outside the defined map.
// Latency: combinational.
// Backpressure: none.
module instr_decoder
   import instr_fetch_decode_pkg::*;
(
   input  logic [INSTR_WIDTH-1:0] word_i,
   output instr_t                 fields_o,
   output logic                   illegal_o
);

   assign fields_o  = instr_t'(word_i);
   assign illegal_o = (fields_o.op_code >= NUM_OPS);

endmodule

// File: rtl/instr_fetch_decode.sv
// Program counter plus fetch FSM: one outstanding read, decode, present to execute, jump/HALT handling.
// Latency: 3 cycles per instruction with 1-cycle memory (FETCH, WAIT, HOLD).
// Backpressure: holds every output stable in HOLD until instr_ready; no new fetch meanwhile.
module instr_fetch_decode
   import instr_fetch_decode_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   instr_fetch_decode_if.master  bus
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
   logic                flush_q, flush_d;
   logic                halted_q, halted_d;
   logic                illegal_q, illegal_d;
   instr_t              fields_q, fields_d;
   instr_t              dec_fields;
   logic                dec_illegal;

   instr_decoder u_decoder (
      .word_i    (bus.prog_data),
      .fields_o  (dec_fields),
      .illegal_o (dec_illegal)
   );

   // State, PC and presented-instruction registers; reset wins immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         pc_out_q  <= '0;
         flush_q   <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         fields_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc_out_q  <= pc_out_d;
         flush_q   <= flush_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         fields_q  <= fields_d;
      end
   end

   // Next-state logic; a jump always redirects pc and any in-flight word is discarded.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pc_out_d  = pc_out_q;
      flush_d   = flush_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      fields_d  = fields_q;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            // The request goes out this cycle regardless; a jump marks its reply stale.
            if (bus.jump_en) begin
               pc_d    = bus.jump_addr;
               flush_d = 1'b1;
            end
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.prog_valid) begin
               if (bus.jump_en) begin
                  pc_d    = bus.jump_addr;
                  flush_d = 1'b0;
                  state_d = FETCH;
               end else if (flush_q) begin
                  flush_d = 1'b0;
                  state_d = FETCH;
               end else begin
                  fields_d  = dec_fields;
                  pc_out_d  = pc_q;
                  illegal_d = illegal_q | dec_illegal;
                  state_d   = HOLD;
               end
            end else if (bus.jump_en) begin
               pc_d    = bus.jump_addr;
               flush_d = 1'b1;
            end
         end
         HOLD: begin
            // Jump outranks HALT: the redirect target is fetched even if HALT was on display.
            if (bus.jump_en) begin
               pc_d    = bus.jump_addr;
               state_d = FETCH;
            end else if (bus.instr_ready) begin
               if (fields_q.op_code == HALT_OP) begin
                  halted_d = 1'b1;
                  state_d  = HALTED;
               end else begin
                  pc_d    = pc_q + PC_WIDTH'(1);
                  state_d = FETCH;
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.prog_rd_en     = (state_q == FETCH);
   assign bus.prog_addr      = (state_q == FETCH) ? pc_q : '0;
   assign bus.instr_valid    = (state_q == HOLD);
   assign bus.op_code        = fields_q.op_code;
   assign bus.source1_choice = fields_q.source1_choice;
   assign bus.source1_addr   = fields_q.source1_addr;
   assign bus.source2_choice = fields_q.source2_choice;
   assign bus.source2_addr   = fields_q.source2_addr;
   assign bus.dest_choice    = fields_q.dest_choice;
   assign bus.dest_addr      = fields_q.dest_addr;
   assign bus.pc_out         = pc_out_q;
   assign bus.halted         = halted_q;
   assign bus.illegal_op     = illegal_q;

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Upstream stage of the proc datapath. Holds the program counter and fetches one instruction word per step from program memory over a variable-latency read handshake.
- Splits each word into op_code, source/dest addresses and source/dest choice fields, and presents them to the execute stage with a valid/ready handshake.
- Handles jump redirects from execute and stops on a HALT opcode.

Parameters:
- OPCODE_WIDTH, 6, op_code field width.
- MEM_WIDTH, 5, width of each address field.
- PC_WIDTH, 8, program counter and program memory address width.
- INSTR_WIDTH, OPCODE_WIDTH+3*(2+MEM_WIDTH) = 27, instruction word width.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- prog_addr, out, PC_WIDTH, program memory read address.
- prog_rd_en, out, 1, one-cycle read request pulse.
- prog_data, in, INSTR_WIDTH, returned instruction word.
- prog_valid, in, 1, prog_data valid this cycle; latency from request is 1 to N cycles.
- jump_en, in, 1, redirect request from execute.
- jump_addr, in, PC_WIDTH, redirect target.
- op_code, out, OPCODE_WIDTH, decoded opcode.
- source1_addr, source2_addr, dest_addr, out, MEM_WIDTH each, decoded addresses.
- source1_choice, source2_choice, dest_choice, out, 2 each, decoded operand selectors, passed through unmodified.
- instr_valid, out, 1, decoded fields are valid.
- instr_ready, in, 1, execute accepts the instruction.
- pc_out, out, PC_WIDTH, address of the instruction currently presented.
- halted, out, 1, HALT has been consumed; sticky until rst.
- illegal_op, out, 1, sticky flag; an opcode >= NUM_OPS was decoded.

Behaviour:
- Reset: all outputs 0, pc=0, state=IDLE, flush flag cleared. Assertion of rst at any point takes effect immediately, mid-operation included. A prog_valid arriving in IDLE is ignored.
- Instruction word, MSB to LSB: op_code | source1_choice | source1_addr | source2_choice | source2_addr | dest_choice | dest_addr.
- FSM states:
  - IDLE: go to FETCH next cycle.
  - FETCH: prog_rd_en=1 and prog_addr=pc for exactly one cycle, then WAIT.
  - WAIT: hold until prog_valid. Register the decoded fields and pc_out=pc, then HOLD.
  - HOLD: instr_valid=1, fields stable. On instr_ready: pc<=pc+1 and go to FETCH, with instr_valid=0 in the next cycle. If op_code==HALT_OP when accepted: go to HALTED instead and set halted=1.
  - HALTED: no requests, instr_valid=0. Leave only on rst.
- Only one memory request is outstanding at a time. Minimum step with 1-cycle memory: FETCH, WAIT, HOLD, so 3 cycles per instruction.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1 wraps to 0x00 with no flag.
- Jump, in order of precedence:
  - In FETCH: pc<=jump_addr and go to WAIT with flush set; the request already issued is discarded.
  - In WAIT: pc<=jump_addr, flush set. When prog_valid arrives, drop the data, clear flush, go to FETCH.
  - In WAIT on the same cycle as prog_valid: data dropped, go to FETCH at jump_addr.
  - In HOLD, with or without instr_ready: instruction counts as consumed if ready=1. pc<=jump_addr, go to FETCH, instr_valid=0 next cycle.
  - In IDLE or HALTED: ignored.
- Illegal opcode (>= NUM_OPS): fields are presented unchanged, and illegal_op is set in the same cycle instr_valid rises. Execution continues.
- While instr_valid=1 and instr_ready=0, every output is stable.

Decomposition:
- instructions package holds:
  - width constants OPCODE_WIDTH, MEM_WIDTH, PC_WIDTH, INSTR_WIDTH;
  - opcode enum including NOP_OP=0 and HALT_OP;
  - NUM_OPS;
  - choice-encoding constants;
  - a packed instr_t struct matching the field order;
  - the fetch state enum.
- One sub-module, instr_decoder: purely combinational word-to-field split plus the illegal-opcode check. The FSM and PC stay in instr_fetch_decode.

Test Plan:
- Sequential fetch: memory latency 1, addr0=ADD, addr1=SUB, ready tied 1. prog_rd_en pulses at addr 0, then 1, then 2 every 3 cycles. op_code sequence is ADD then SUB, with pc_out 0 then 1.
- Backpressure: ready held 0 for 5 cycles in HOLD. instr_valid and all fields are stable for 5 cycles. No prog_rd_en until ready=1.
- Variable latency with jump: latency 4, jump_en with jump_addr=0x40 in cycle 2 of WAIT. The returned word is not presented. Next prog_addr=0x40 and pc_out=0x40.
- Jump in HOLD with ready=1 on the same cycle, jump_addr=0x10. Instruction is consumed once. Next fetch address is 0x10, not pc+1.
- Wrap and HALT: start from jump_addr=0xFF with a NOP there. Next fetch is 0x00; HALT at 0x00 is accepted, halted=1, and prog_rd_en stays 0 for 20 cycles. rst then gives pc=0, halted=0.
- Async reset and illegal opcode: rst asserted mid-WAIT, off-edge. Outputs go to 0 before the next clk edge, and a late prog_valid is ignored. Opcode 0x3F (>= NUM_OPS) sets illegal_op=1, which stays high.
